// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg7_pkg;
    typedef enum logic [1:0] {OFF, GUARD, DRIVE} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam int         N_DIGITS  = 4;

    typedef logic [3:0] hex_t;
endpackage

// File: rtl/seg7_hex_dec.sv
// Hex digit to active-low {g,f,e,d,c,b,a} segment pattern, purely combinational.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  hex_t       hex_i,
    output logic [6:0] seg_o
);
    // All 16 codes are listed, so no fallback item is needed.
    always_comb begin
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Guarded, double-buffered scan controller for a 4-digit common-anode display.
// Define SEG7_LZ_BLANK_EN to suppress leading zeros on digits 3..1.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DRIVE_CYC = 50000,
    parameter int GUARD_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [3:0] din3,
    input  logic [3:0] blank_mask,
    output logic [3:0] an,
    output logic [6:0] dout,
    output logic [1:0] addr,
    output logic       frame_done
);
    localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYC - 1);

    scan_state_t                  state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                   addr_q, addr_d;
    hex_t [N_DIGITS-1:0]          active_q, active_d, pending_q, pending_d, din_w;
    logic                         pend_q, pend_d;
    logic [3:0]                   an_q, an_d;
    logic [6:0]                   dout_q, dout_d, cur_seg;
    logic [1:0]                   addr_out_q, addr_out_d;
    logic                         fd_q, fd_d;
    logic                         boundary;
    logic [N_DIGITS-1:0]          lz_blank;

    assign din_w    = {din3, din2, din1, din0};
    assign boundary = en && (state_q == DRIVE) && (addr_q == 2'd3) && (cnt_q == DRV_LAST);

    seg7_hex_dec u_dec (.hex_i(active_q[addr_q]), .seg_o(cur_seg));

    always_comb begin
        lz_blank = '0;
`ifdef SEG7_LZ_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                zero_above  = zero_above && (active_q[i] == 4'h0);
                lz_blank[i] = zero_above;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        if (!en) begin
            state_d = OFF;
            cnt_d   = '0;
            addr_d  = 2'd0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    addr_d  = 2'd0;
                end
                GUARD: begin
                    if (cnt_q == GRD_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRV_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                        addr_d  = addr_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                    addr_d  = 2'd0;
                end
            endcase
        end
    end

    // New digits only reach the display at a frame boundary, or while dark.
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (ld && boundary) begin
            active_d = din_w;
            pend_d   = 1'b0;
        end else begin
            if (pend_q && (boundary || state_q == OFF)) begin
                active_d = pending_q;
                pend_d   = 1'b0;
            end
            if (ld) begin
                pending_d = din_w;
                pend_d    = 1'b1;
            end
        end
    end

    always_comb begin
        an_d       = 4'b1111;
        dout_d     = SEG_BLANK;
        addr_out_d = en ? addr_q : 2'd0;
        fd_d       = boundary;
        if (en && state_q == DRIVE && !(blank_mask[addr_q] || lz_blank[addr_q])) begin
            an_d[addr_q] = 1'b0;
            dout_d       = cur_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            addr_q     <= 2'd0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_q     <= 1'b0;
            an_q       <= 4'b1111;
            dout_q     <= SEG_BLANK;
            addr_out_q <= 2'd0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            dout_q     <= dout_d;
            addr_out_q <= addr_out_d;
            fd_q       <= fd_d;
        end
    end

    assign an         = an_q;
    assign dout       = dout_q;
    assign addr       = addr_out_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl using a frame-position reference model.
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    localparam int DRV   = 8;
    localparam int GRD   = 2;
    localparam int SLOT  = GRD + DRV;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n, en, ld;
    logic [3:0] din0, din1, din2, din3, blank_mask;
    logic [3:0] an;
    logic [6:0] dout;
    logic [1:0] addr;
    logic       frame_done;

    seg7_scan_ctrl #(.DRIVE_CYC(DRV), .GUARD_CYC(GRD), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .blank_mask(blank_mask), .an(an), .dout(dout), .addr(addr),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] dout;
        logic [1:0] addr;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: display timing follows from the cycle count since enable.
    bit   running;
    int   s;
    hex_t m_active[4];
    hex_t m_pending[4];
    bit   m_pend;

    function automatic bit blanked(input int i);
        bit r;
        r = blank_mask[i];
`ifdef SEG7_LZ_BLANK_EN
        if (i != 0) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int j = i; j < 4; j++) if (m_active[j] != 4'h0) all_zero = 1'b0;
            r = r || all_zero;
        end
`endif
        return r;
    endfunction

    initial begin
        forever begin
            exp_t e;
            hex_t d[4];
            bit   bnd, off;
            int   q, dig;
            @(posedge clk);
            d = '{din0, din1, din2, din3};
            e = '{an: 4'b1111, dout: SEG_BLANK, addr: 2'd0, fd: 1'b0};
            if (!rst_n) begin
                running = 0;
                s       = 0;
                m_pend  = 0;
                for (int i = 0; i < 4; i++) begin
                    m_active[i]  = 4'h0;
                    m_pending[i] = 4'h0;
                end
            end else begin
                bnd = en && running && (s % FRAME) == FRAME - 1;
                off = !running;
                if (en && running) begin
                    q      = s % FRAME;
                    dig    = q / SLOT;
                    e.addr = 2'(dig);
                    e.fd   = bnd;
                    if ((q % SLOT) >= GRD && !blanked(dig)) begin
                        e.an   = ~(4'b0001 << dig);
                        e.dout = FONT[m_active[dig]];
                    end
                end
                if (ld && bnd) begin
                    m_active = d;
                    m_pend   = 0;
                end else begin
                    if (m_pend && (bnd || off)) begin
                        m_active = m_pending;
                        m_pend   = 0;
                    end
                    if (ld) begin
                        m_pending = d;
                        m_pend    = 1;
                    end
                end
                if (!en) running = 0;
                else if (running) s++;
                else begin
                    running = 1;
                    s       = 0;
                end
            end
            sb_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per presented output cycle.
    initial begin
        logic fd_prev;
        fd_prev = 1'b0;
        forever begin
            exp_t ex;
            exp_t got;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                ex  = sb_q.pop_front();
                got = '{an: an, dout: dout, addr: addr, fd: frame_done};
                checks++;
                if (got !== ex) begin
                    failures++;
                    $display("FAIL outputs t=%0t an=%b exp %b dout=%h exp %h addr=%0d exp %0d frame_done=%b exp %b",
                             $time, an, ex.an, dout, ex.dout, addr, ex.addr, frame_done, ex.fd);
                end
                checks++;
                if ($countones(~an) > 1) begin
                    failures++;
                    $display("FAIL an_onehot t=%0t an=%b exp at most one zero", $time, an);
                end
                checks++;
                if (frame_done === 1'b1 && fd_prev === 1'b1) begin
                    failures++;
                    $display("FAIL frame_done_width t=%0t frame_done=1 exp single-cycle pulse", $time);
                end
                fd_prev = frame_done;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] d3, d2, d1, d0);
        din3 = d3; din2 = d2; din1 = d1; din0 = d0;
        ld   = 1'b1;
        tick();
        ld   = 1'b0;
    endtask

    function automatic logic [3:0] rnd_digit();
        return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; ld = 1'b0; blank_mask = 4'b0000;
        din0 = 4'h0; din1 = 4'h0; din2 = 4'h0; din3 = 4'h0;
        tick(3);
        rst_n = 1'b1;
        tick(20);

        load(4'h3, 4'h2, 4'h1, 4'h0);
        en = 1'b1;
        tick(2 * FRAME);

        tick(15);
        load(4'hA, 4'hA, 4'hA, 4'hA);
        tick(FRAME);
        load(4'h1, 4'h2, 4'h3, 4'h4);
        tick(5);
        load(4'h9, 4'h8, 4'h7, 4'h6);
        tick(2 * FRAME);

        blank_mask = 4'b0100;
        tick(FRAME);
        blank_mask = 4'b0000;

        tick(SLOT * 2 + GRD + 3);
        en = 1'b0;
        tick(5);
        en = 1'b1;
        tick(FRAME);

        load(4'h0, 4'h0, 4'h5, 4'h0);
        tick(2 * FRAME);
        load(4'h0, 4'h0, 4'h0, 4'h0);
        tick(2 * FRAME);

        for (int c = 0; c < 3000; c++) begin
            ld = ($urandom_range(0, 7) == 0);
            if (ld) begin
                din0 = rnd_digit(); din1 = rnd_digit(); din2 = rnd_digit(); din3 = rnd_digit();
            end
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 63) == 0) blank_mask = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end
        ld = 1'b0;
        rst_n = 1'b1;
        tick(2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
